// File: rtl/muu_pkg.sv
// muu_pkg: op codes, FSM states and helpers for the HI/LO multiply/divide unit.
// Ports: none (package).
package muu_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

  // Signed variants sit on the even codes below MTHI.
  function automatic logic op_signed(logic [3:0] op);
    return !op[0] && (op < OP_MTHI);
  endfunction

  function automatic logic op_div(logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_mul(logic [3:0] op);
    return (op < OP_MTHI) && !op_div(op);
  endfunction

  function automatic logic op_madd(logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic op_msub(logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muu_if.sv
// muu_if: request/result bundle between the datapath and the MUU.
// Ports: start/op/rs_value/rt_value (req), busy/done/div_by_zero/hi/lo (rsp).
interface muu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs_value;
  logic [WIDTH-1:0] rt_value;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_value, rt_value,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_value, rt_value,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muu_divider.sv
// muu_divider: restoring unsigned divider, one quotient bit per step.
// Ports: clk, load, step, dividend, divisor in; quotient, remainder out.
module muu_divider #(
  parameter int WIDTH = muu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   dif;

  // rem < dvs always holds, so a successful
  // trial subtract fits back into WIDTH bits.
  assign shf = {rem, quo[WIDTH-1]};
  assign dif = shf - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      if (!dif[WIDTH]) begin
        rem <= dif[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shf[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muu_iterative.sv
// muu_iterative: multi-cycle HI/LO unit (MULT/DIV/MADD/MSUB/MTHI/MTLO).
// Ports: muu_clock, reset (sync, high), bus (muu_if.slave).
module muu_iterative #(
  parameter int WIDTH     = muu_pkg::WIDTH,
  parameter int MUL_ITERS = WIDTH,
  parameter int DIV_ITERS = WIDTH
) (
  input  logic   muu_clock,
  input  logic   reset,
  muu_if.slave   bus
);
  import muu_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic             neg_ab;
  logic             neg_r;
  logic [WIDTH-1:0] mcand;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic             sgn;
  logic             rt_zero;
  logic             div_load;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   psum;
  logic [W2-1:0]    pfix;
  logic [W2-1:0]    acc;

  assign sgn     = op_signed(bus.op);
  assign rt_zero = (bus.rt_value == '0);

  assign a_mag = (sgn && bus.rs_value[WIDTH-1])
               ? -bus.rs_value : bus.rs_value;
  assign b_mag = (sgn && bus.rt_value[WIDTH-1])
               ? -bus.rt_value : bus.rt_value;

  assign div_load = (state == ST_IDLE) && bus.start
                  && op_div(bus.op) && !rt_zero;

  muu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (muu_clock),
    .load      (div_load),
    .step      (state == ST_DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Multiplier sits in prod's low half and
  // shifts out as the partial sum shifts in.
  assign psum = {1'b0, prod[W2-1:WIDTH]}
              + (prod[0] ? {1'b0, mcand} : '0);

  assign pfix = neg_ab ? -prod : prod;
  assign acc  = {hi_q, lo_q};

  always_ff @(posedge muu_clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            cnt    <= '0;
            neg_ab <= sgn && (bus.rs_value[WIDTH-1]
                            ^ bus.rt_value[WIDTH-1]);
            neg_r  <= sgn && bus.rs_value[WIDTH-1];
            unique case (1'b1)
              bus.op == OP_MTHI: begin
                hi_q   <= bus.rs_value;
                done_q <= 1'b1;
              end
              bus.op == OP_MTLO: begin
                lo_q   <= bus.rs_value;
                done_q <= 1'b1;
              end
              op_div(bus.op) && rt_zero: begin
                done_q <= 1'b1;
                dbz_q  <= 1'b1;
              end
              op_div(bus.op) && !rt_zero: begin
                state  <= ST_DIV;
                busy_q <= 1'b1;
              end
              op_mul(bus.op): begin
                state  <= ST_MUL;
                busy_q <= 1'b1;
                mcand  <= a_mag;
                prod   <= {{WIDTH{1'b0}}, b_mag};
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          prod <= {psum, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(MUL_ITERS - 1))
            state <= ST_FIX;
        end
        ST_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_ITERS - 1))
            state <= ST_FIX;
        end
        ST_FIX: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          unique case (1'b1)
            op_div(op_q): begin
              lo_q <= neg_ab ? -quo : quo;
              hi_q <= neg_r ? -rem : rem;
            end
            op_madd(op_q): {hi_q, lo_q} <= acc + pfix;
            op_msub(op_q): {hi_q, lo_q} <= acc - pfix;
            default:       {hi_q, lo_q} <= pfix;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
